// File: rtl/pulse_sched_pkg.sv
// pulse_sched_pkg
//   Shared types and helpers for the pulse scheduler: FSM state encoding,
//   a constant clog2 and the round-robin first-set search.
package pulse_sched_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PULSE = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    localparam int MAX_REQ = 8;

    // Width of a binary index for v items (at least 1 bit).
    function automatic int clog2(input int v);
        int r;
        for (r = 0; (1 << r) < v; r++) begin
        end
        return (r == 0) ? 1 : r;
    endfunction

    // First set bit of pend searching upward from (last+1) mod n, with wrap.
    // Scanning from the farthest offset down lets the nearest hit win.
    function automatic int rr_pick(input logic [MAX_REQ-1:0] pend, input int last, input int n);
        int win;
        int idx;
        win = 0;
        for (int i = n; i >= 1; i--) begin
            idx = (last + i) % n;
            if (pend[idx]) win = idx;
        end
        return win;
    endfunction

endpackage

// File: rtl/pulse_sched_if.sv
// pulse_sched_if
//   Requester/control bundle of the pulse scheduler.
//   master: drives en, req; observes pulse_out, grant, pulse_sel, busy, done, pending.
//   slave : the scheduler side.
interface pulse_sched_if #(
    parameter int N_REQ = 4,
    parameter int SEL_W = pulse_sched_pkg::clog2(N_REQ)
);
    logic             en;
    logic [N_REQ-1:0] req;
    logic             pulse_out;
    logic [N_REQ-1:0] grant;
    logic [SEL_W-1:0] pulse_sel;
    logic             busy;
    logic [N_REQ-1:0] done;
    logic [N_REQ-1:0] pending;

    modport master (output en, req,
                    input  pulse_out, grant, pulse_sel, busy, done, pending);
    modport slave  (input  en, req,
                    output pulse_out, grant, pulse_sel, busy, done, pending);
endinterface

// File: rtl/pulse_sched_timer.sv
// pulse_sched_timer
//   CNT_W down-counter used for pulse and gap timing. Stops at zero.
//   i_load/i_load_val : load a new count (wins over decrement)
//   i_dec             : decrement by one when not already zero
//   o_zero            : count is zero
module pulse_sched_timer #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    input  logic             i_dec,
    output logic             o_zero
);
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                     r_cnt <= '0;
        else if (i_load)                r_cnt <= i_load_val;
        else if (i_dec && r_cnt != '0)  r_cnt <= r_cnt - 1'b1;
    end

    assign o_zero = (r_cnt == '0);
endmodule

// File: rtl/pulse_sched.sv
// pulse_sched
//   Shares one PULSE_LEN-cycle timing pulse (plus GAP_LEN recovery) among
//   N_REQ requesters. Request rising edges are latched into pending and
//   served one at a time in round-robin order; the owner gets a one-cycle
//   done strobe when its service (pulse + gap) ends.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : slave side of pulse_sched_if (en, req in; pulse_out, grant,
//                pulse_sel, busy, done, pending out)
module pulse_sched
    import pulse_sched_pkg::*;
#(
    parameter int N_REQ     = 4,
    parameter int PULSE_LEN = 128,
    parameter int GAP_LEN   = 16,
    parameter int CNT_W     = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    pulse_sched_if.slave bus
);
    localparam int SEL_W = clog2(N_REQ);

    state_t           r_state, w_next;
    logic [N_REQ-1:0] r_req_q, r_pend, r_grant, r_done;
    logic [SEL_W-1:0] r_sel, r_last;
    logic             r_pulse, r_busy;

    logic [N_REQ-1:0] w_rise, w_clr;
    logic [SEL_W-1:0] w_win;
    logic             w_start, w_pulse_end, w_svc_end, w_ld, w_zero;
    logic [CNT_W-1:0] w_ld_val;

    assign w_rise = bus.req & ~r_req_q;
    assign w_win  = SEL_W'(rr_pick(MAX_REQ'(r_pend), int'(r_last), N_REQ));
    // One-hot of the requester granted on this edge; clears its pending bit.
    assign w_clr  = w_start ? (N_REQ'(1) << w_win) : '0;

    pulse_sched_timer #(.CNT_W(CNT_W)) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_ld),
        .i_load_val (w_ld_val),
        .i_dec      (r_state != S_IDLE),
        .o_zero     (w_zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next      = r_state;
        w_start     = 1'b0;
        w_pulse_end = 1'b0;
        w_svc_end   = 1'b0;
        w_ld        = 1'b0;
        w_ld_val    = '0;
        case (r_state)
            S_IDLE: begin
                if (bus.en && |r_pend) begin
                    w_next   = S_PULSE;
                    w_start  = 1'b1;
                    w_ld     = 1'b1;
                    w_ld_val = CNT_W'(PULSE_LEN - 1);
                end
            end
            S_PULSE: begin
                if (w_zero) begin
                    w_pulse_end = 1'b1;
                    if (GAP_LEN > 0) begin
                        w_next   = S_GAP;
                        w_ld     = 1'b1;
                        w_ld_val = CNT_W'(GAP_LEN - 1);
                    end else begin
                        w_next    = S_IDLE;
                        w_svc_end = 1'b1;
                    end
                end
            end
            S_GAP: begin
                if (w_zero) begin
                    w_next    = S_IDLE;
                    w_svc_end = 1'b1;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_req_q <= '0;
            r_pend  <= '0;
            r_grant <= '0;
            r_done  <= '0;
            r_sel   <= '0;
            r_last  <= SEL_W'(N_REQ - 1);   // index 0 wins the first search
            r_pulse <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_req_q <= bus.req;
            r_pend  <= (r_pend | w_rise) & ~w_clr;
            r_done  <= '0;
            if (w_start) begin
                r_grant <= w_clr;
                r_sel   <= w_win;
                r_last  <= w_win;
                r_pulse <= 1'b1;
                r_busy  <= 1'b1;
            end
            if (w_pulse_end) r_pulse <= 1'b0;
            if (w_svc_end) begin
                r_done  <= r_grant;
                r_grant <= '0;
                r_busy  <= 1'b0;
            end
        end
    end

    assign bus.pulse_out = r_pulse;
    assign bus.grant     = r_grant;
    assign bus.pulse_sel = r_sel;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.pending   = r_pend;
endmodule

// File: tb/tb_pulse_sched.sv
// tb_pulse_sched
//   Scoreboard bench for pulse_sched. Two instances share clk/rst_n:
//   d1 with PULSE_LEN=4, GAP_LEN=2 and d2 with PULSE_LEN=4, GAP_LEN=0.
//   Stimulus pushes expected pulse starts and done strobes (with the edge
//   number they must appear after); negedge monitors pop and compare.
module tb_pulse_sched;
    logic clk;
    logic rst_n;
    int   cyc;
    int   n_chk;
    int   n_fail;

    typedef struct {
        int       kind;   // 0 = pulse start, 1 = done strobe
        logic [3:0] vec;
        int       sel;
        int       c;
    } exp_t;

    exp_t q1[$];
    exp_t q2[$];
    int   pw1, pw2;

    pulse_sched_if #(.N_REQ(4)) b1();
    pulse_sched_if #(.N_REQ(4)) b2();

    pulse_sched #(.N_REQ(4), .PULSE_LEN(4), .GAP_LEN(2), .CNT_W(16)) d1 (
        .clk(clk), .rst_n(rst_n), .bus(b1));
    pulse_sched #(.N_REQ(4), .PULSE_LEN(4), .GAP_LEN(0), .CNT_W(16)) d2 (
        .clk(clk), .rst_n(rst_n), .bus(b2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cyc %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic push(input int d, input int kind, input logic [3:0] v, input int sel, input int c);
        exp_t e;
        e.kind = kind; e.vec = v; e.sel = sel; e.c = c;
        if (d == 0) q1.push_back(e);
        else        q2.push_back(e);
    endtask

    task automatic sb_check(input int d, input int kind, input logic [3:0] v, input int sel);
        exp_t e;
        bit   ok;
        ok = 1'b0;
        if (d == 0 && q1.size() > 0) begin e = q1.pop_front(); ok = 1'b1; end
        if (d == 1 && q2.size() > 0) begin e = q2.pop_front(); ok = 1'b1; end
        if (!ok) begin
            n_chk++;
            n_fail++;
            $display("FAIL sb%0d unexpected event kind=%0d vec=%b cyc=%0d", d, kind, v, cyc);
        end else begin
            check("event kind", kind, e.kind);
            check("event cycle", cyc, e.c);
            check(kind == 0 ? "grant" : "done", {28'd0, v}, {28'd0, e.vec});
            if (kind == 0) check("pulse_sel", sel, e.sel);
        end
    endtask

    // Monitors: done strobe first, then pulse start, then pulse width.
    always @(negedge clk) begin
        if (!rst_n) pw1 <= 0;
        else begin
            if (b1.done != 4'b0) sb_check(0, 1, b1.done, 0);
            if (b1.pulse_out && pw1 == 0) begin
                sb_check(0, 0, b1.grant, int'(b1.pulse_sel));
                check("d1 busy at start", b1.busy, 1);
            end
            if (b1.pulse_out) pw1 <= pw1 + 1;
            else begin
                if (pw1 != 0) check("d1 pulse width", pw1, 4);
                pw1 <= 0;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst_n) pw2 <= 0;
        else begin
            if (b2.done != 4'b0) sb_check(1, 1, b2.done, 0);
            if (b2.pulse_out && pw2 == 0) sb_check(1, 0, b2.grant, int'(b2.pulse_sel));
            if (b2.pulse_out) pw2 <= pw2 + 1;
            else begin
                if (pw2 != 0) check("d2 pulse width", pw2, 4);
                pw2 <= 0;
            end
        end
    end

    initial begin
        int k;
        n_chk = 0; n_fail = 0;
        rst_n = 1'b0;
        b1.en = 1'b1; b1.req = 4'b0;
        b2.en = 1'b1; b2.req = 4'b0;
        repeat (2) @(negedge clk);
        check("rst pulse_out", b1.pulse_out, 0);
        check("rst grant",     b1.grant, 0);
        check("rst pulse_sel", b1.pulse_sel, 0);
        check("rst busy",      b1.busy, 0);
        check("rst done",      b1.done, 0);
        check("rst pending",   b1.pending, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Simultaneous rise on 0 and 2 with rr_last=3: 0 first, then 2.
        k = cyc + 1; b1.req = 4'b0101;
        push(0, 0, 4'b0001, 0, k + 1);  push(0, 1, 4'b0001, 0, k + 7);
        push(0, 0, 4'b0100, 2, k + 8);  push(0, 1, 4'b0100, 2, k + 14);
        @(negedge clk); b1.req = 4'b0;
        check("t2 pending", b1.pending, 4'b0101);
        repeat (16) @(negedge clk);

        // Single request on 1: timing of pulse, busy, done, pending.
        k = cyc + 1; b1.req = 4'b0010;
        push(0, 0, 4'b0010, 1, k + 1);  push(0, 1, 4'b0010, 1, k + 7);
        @(negedge clk); b1.req = 4'b0;
        check("t1 pending set", b1.pending, 4'b0010);
        @(negedge clk);
        check("t1 pending clr", b1.pending, 4'b0000);
        repeat (5) @(negedge clk);
        check("t1 busy in gap", b1.busy, 1);
        @(negedge clk);
        check("t1 busy after", b1.busy, 0);
        repeat (3) @(negedge clk);

        // Owner 3 re-requests twice while busy: exactly one extra service.
        k = cyc + 1; b1.req = 4'b1000;
        push(0, 0, 4'b1000, 3, k + 1);  push(0, 1, 4'b1000, 3, k + 7);
        push(0, 0, 4'b1000, 3, k + 8);  push(0, 1, 4'b1000, 3, k + 14);
        @(negedge clk); b1.req = 4'b0;
        @(negedge clk);
        @(negedge clk); b1.req = 4'b1000;
        @(negedge clk); b1.req = 4'b0;
        @(negedge clk); b1.req = 4'b1000;
        @(negedge clk); b1.req = 4'b0;
        @(negedge clk);
        check("t3 pending merge", b1.pending, 4'b1000);
        check("t3 grant", b1.grant, 4'b1000);
        repeat (10) @(negedge clk);

        // en=0 holds off grants while pending accumulates.
        b1.en = 1'b0;
        k = cyc + 1; b1.req = 4'b0011;
        @(negedge clk); b1.req = 4'b0;
        repeat (3) @(negedge clk);
        check("t4 pending held", b1.pending, 4'b0011);
        check("t4 no pulse", b1.pulse_out, 0);
        b1.en = 1'b1;
        k = cyc + 1;
        push(0, 0, 4'b0001, 0, k);      push(0, 1, 4'b0001, 0, k + 6);
        push(0, 0, 4'b0010, 1, k + 7);  push(0, 1, 4'b0010, 1, k + 13);
        repeat (16) @(negedge clk);

        // Asynchronous reset mid-pulse; 1 left pending is dropped too.
        k = cyc + 1; b1.req = 4'b0110;
        push(0, 0, 4'b0100, 2, k + 1);
        @(negedge clk); b1.req = 4'b0;
        repeat (2) @(negedge clk);
        check("t5 pending pre", b1.pending, 4'b0010);
        #2 rst_n = 1'b0;
        #1;
        check("t5 pulse_out", b1.pulse_out, 0);
        check("t5 busy",      b1.busy, 0);
        check("t5 grant",     b1.grant, 0);
        check("t5 pending",   b1.pending, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        check("t5 no pulse after", b1.pulse_out, 0);
        check("t5 pending after",  b1.pending, 0);

        // GAP_LEN=0: one IDLE cycle carries the done strobe.
        k = cyc + 1; b2.req = 4'b0011;
        push(1, 0, 4'b0001, 0, k + 1);  push(1, 1, 4'b0001, 0, k + 5);
        push(1, 0, 4'b0010, 1, k + 6);  push(1, 1, 4'b0010, 1, k + 10);
        @(negedge clk); b2.req = 4'b0;
        repeat (5) @(negedge clk);
        check("t6 idle pulse_out", b2.pulse_out, 0);
        check("t6 idle busy", b2.busy, 0);
        repeat (8) @(negedge clk);

        check("sb1 drained", q1.size(), 0);
        check("sb2 drained", q2.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
